// File: rtl/led_pwm_fader.sv
// PWM LED output stage with linear per-channel brightness ramps and a shared brightness cap.
// Optional quadratic duty correction is enabled by defining LED_PWM_FADER_GAMMA_EN.
module led_pwm_fader #(
  parameter int NUM_LED       = 4,
  parameter int PWM_BITS      = 8,
  parameter int RAMP_DIV_BITS = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LED-1:0]          led_in,
  input  logic [PWM_BITS-1:0]         max_level,
  output logic [NUM_LED-1:0]          led_out,
  output logic [NUM_LED*PWM_BITS-1:0] level_out,
  output logic                        busy
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_RISE = 2'd2,
    ST_FALL = 2'd3
  } ch_state_e;

  localparam logic [RAMP_DIV_BITS-1:0] PRESC_ONE = 1;
  localparam logic [PWM_BITS-1:0]      PWM_ONE   = 1;

  logic [NUM_LED-1:0]       led_q, led_d;
  logic [RAMP_DIV_BITS-1:0] presc_q, presc_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LED-1:0]       led_out_q, led_out_d;
  logic                     busy_q, busy_d;
  logic                     ramp_tick;
  logic [NUM_LED-1:0]       ramping;

  always_comb begin
    led_d     = led_in;
    presc_d   = presc_q + PRESC_ONE;
    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    ramp_tick = &presc_q;
    busy_d    = |ramping;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      led_out_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      led_q     <= led_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
      busy_q    <= busy_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_ch
      logic [PWM_BITS-1:0] level_q, level_d;
      logic [PWM_BITS-1:0] target;
      logic [PWM_BITS-1:0] duty;
      ch_state_e           state;

      // Single-step moves toward the target can never overshoot or wrap.
      always_comb begin
        target  = led_q[gi] ? max_level : '0;
        level_d = level_q;
        if (ramp_tick) begin
          if (level_q < target) begin
            level_d = level_q + PWM_ONE;
          end else if (level_q > target) begin
            level_d = level_q - PWM_ONE;
          end
        end
      end

      always_comb begin
        state = ST_OFF;
        if (level_q < target) begin
          state = ST_RISE;
        end else if (level_q > target) begin
          state = ST_FALL;
        end else if (target != '0) begin
          state = ST_ON;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          level_q <= '0;
        end else begin
          level_q <= level_d;
        end
      end

`ifdef LED_PWM_FADER_GAMMA_EN
      logic [2*PWM_BITS-1:0] level_sq;
      assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
      assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
      assign duty = level_q;
`endif

      // Strict compare: full-scale level leaves one dark slot per PWM period.
      assign led_out_d[gi] = (pwm_cnt_q < duty);
      assign ramping[gi]   = (state == ST_RISE) || (state == ST_FALL);
      assign level_out[gi*PWM_BITS +: PWM_BITS] = level_q;
    end
  endgenerate

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed scoreboard bench for led_pwm_fader with NUM_LED=4, PWM_BITS=4, RAMP_DIV_BITS=2.
module tb_led_pwm_fader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  led_in = 4'h0;
  logic [3:0]  max_level = 4'h0;
  logic [3:0]  led_out;
  logic [15:0] level_out;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];

  always #4 clk = ~clk;

  led_pwm_fader #(
    .NUM_LED      (4),
    .PWM_BITS     (4),
    .RAMP_DIV_BITS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .max_level(max_level),
    .led_out  (led_out),
    .level_out(level_out),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pops one expected level per observed change of channel 0; steps must be one tick apart.
  task automatic run_changes(input string tag, input int budget, input bit settle);
    int prev;
    int last;
    int n;
    bit first;
    prev  = int'(level_out[3:0]);
    last  = cyc;
    first = 1'b1;
    n     = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
      if (int'(level_out[3:0]) != prev) begin
        check({tag, "_level"}, level_out[3:0], exp_q.pop_front());
        check({tag, "_busy"}, busy, 1);
        if (!first) check({tag, "_step_gap"}, cyc - last, 4);
        first = 1'b0;
        last  = cyc;
        prev  = int'(level_out[3:0]);
      end
    end
    if (exp_q.size() > 0) begin
      check({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    if (settle) begin
      tick();
      check({tag, "_busy_settle"}, busy, 0);
    end
  endtask

  task automatic duty(input string tag, input int exp_on);
    int on0;
    int other;
    on0   = 0;
    other = 0;
    for (int k = 0; k < 16; k++) begin
      if (led_out[0]) on0++;
      if (led_out[3:1] != 3'b000) other++;
      tick();
    end
    check({tag, "_duty0"}, on0, exp_on);
    check({tag, "_other_off"}, other, 0);
  endtask

  initial begin
    int gamma_exp;
`ifdef LED_PWM_FADER_GAMMA_EN
    gamma_exp = 4;
`else
    gamma_exp = 8;
`endif

    // Reset held two cycles with all channels requested on
    rst = 1'b1; led_in = 4'hF; max_level = 4'd15;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_led_out", led_out, 0);
      check("rst_level_out", level_out, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; led_in = 4'b0001;
    tick();
    check("post_rst_led_out", led_out, 0);
    check("post_rst_level_out", level_out, 0);
    check("post_rst_busy", busy, 0);

    // Ramp up to full scale
    for (int v = 1; v <= 15; v++) exp_q.push_back(v);
    run_changes("ramp", 80, 1'b1);
    check("ramp_other_levels", level_out[15:4], 0);
    duty("full", 15);

    // Cap lowered while ON
    max_level = 4'd4;
    for (int v = 14; v >= 4; v--) exp_q.push_back(v);
    run_changes("cap_fall", 80, 1'b1);
    repeat (12) tick();
    check("cap_hold_level", level_out[3:0], 4);
    check("cap_hold_busy", busy, 0);
    duty("cap", 4);

    // Cap raised again, then reversed at level 6
    max_level = 4'd15;
    exp_q.push_back(5);
    exp_q.push_back(6);
    run_changes("cap_rise", 20, 1'b0);
    led_in = 4'b0000;
    for (int v = 5; v >= 0; v--) exp_q.push_back(v);
    run_changes("reverse", 40, 1'b1);
    check("reverse_levels_zero", level_out, 0);
    duty("reverse_off", 0);

    // Reset in the middle of a ramp
    led_in = 4'b0001;
    for (int v = 1; v <= 9; v++) exp_q.push_back(v);
    run_changes("pre_rst", 60, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_level_out", level_out, 0);
    check("midrst_led_out", led_out, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    for (int v = 1; v <= 3; v++) exp_q.push_back(v);
    run_changes("restart", 30, 1'b0);

    // Hold at level 8 for the duty-curve check
    max_level = 4'd8;
    for (int v = 4; v <= 8; v++) exp_q.push_back(v);
    run_changes("gamma_rise", 40, 1'b1);
    check("gamma_level", level_out[3:0], 8);
    duty("gamma", gamma_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Output stage placed directly downstream of `led_blink`. Takes the per-LED on/off vector and drives the board LEDs with PWM, ramping each channel's brightness linearly up or down instead of switching hard. Also applies a run-time brightness cap shared by all channels. It is a pure consumer of `led_blink`'s `led` bus, with no handshake back.

## Interface
- `NUM_LED`, 4: number of channels.
- `PWM_BITS`, 8: width of the PWM counter and of each brightness level.
- `RAMP_DIV_BITS`, 10: ramp prescaler width; one brightness step every 2^RAMP_DIV_BITS clocks.

- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `led_in`  in  NUM_LED  on/off request per channel (from `led_blink`); asynchronous-safe not required, same clock domain.
- `max_level`  in  PWM_BITS  brightness cap; target level for channels requested on.
- `led_out`  out  NUM_LED  registered PWM drive to pins, active-high.
- `level_out`  out  NUM_LED*PWM_BITS  current level per channel; channel i at bits [i*PWM_BITS +: PWM_BITS].
- `busy`  out  1  high while any channel is ramping.

## Operation
- **Input register.** `led_q <= led_in` every cycle, so there is 1 cycle of input latency.
- **Prescaler.**
  - Free-running RAMP_DIV_BITS counter that wraps naturally.
  - `ramp_tick` is asserted for the single cycle in which the counter equals all-ones.
- **Target.** `target[i] = led_q[i] ? max_level : 0`.
- **Level update.** Only on `ramp_tick`:
  - If `level < target`, add 1.
  - If `level > target`, subtract 1.
  - If equal, hold.
  - Saturating by construction; the level never wraps and never overshoots the target.
- **Per-channel FSM** (2-bit, evaluated every cycle from the registered level and target):
  - OFF: `level==0` and `target==0`.
  - ON: `level==target` and `target!=0`.
  - RISE: `level<target`.
  - FALL: `level>target`.
- **FSM transitions** follow from level/target changes:
  - Toggling `led_in` mid-ramp moves RISE to FALL (or FALL to RISE) and continues from the current level with no jump.
  - Lowering `max_level` below the current level moves ON to FALL, which settles at the new cap.
  - Raising `max_level` moves ON to RISE.
- **`busy`.** Registered OR over channels of (state is RISE or FALL).
- **PWM.**
  - `pwm_cnt` is a free-running PWM_BITS counter wrapping from 2^PWM_BITS-1 to 0.
  - `led_out[i] <= (pwm_cnt < duty[i])`.
  - `duty = level` (see Configuration for the gamma option).
  - Level 0 is constantly off.
  - Level 2^PWM_BITS-1 is on for (2^PWM_BITS-1) of every 2^PWM_BITS cycles; 100 % duty is intentionally unreachable.

## Timing
- **Reset values** (on the cycle after `rst` is sampled high):
  - `led_out=0`, `level_out=0`, `busy=0`.
  - All FSMs in OFF.
  - `pwm_cnt=0`, prescaler=0, `led_q=0`.
- **Reset mid-ramp.** Identical result: levels drop to 0 immediately, with no fade.
- **Latency from `led_in` change to first level change.** 1 cycle (`led_q`), plus wait to the next `ramp_tick`, plus 1 cycle for the level register. Worst case is 2^RAMP_DIV_BITS+1 cycles.
- **Full ramp.** 0 to L takes L ticks, i.e. L·2^RAMP_DIV_BITS cycles, ±2^RAMP_DIV_BITS for phase.
- **`led_out`** reflects a level change from the next PWM compare, 1 cycle after the level register updates.
- **`busy`** lags the FSM state by 1 cycle.
- **Simultaneous `ramp_tick` and `led_in` edge.** The tick uses the old `led_q`, so the new request takes effect on the following tick.

## Configuration
- Macro: `LED_PWM_FADER_GAMMA_EN`.
- **Defined:** `duty[i] = (level[i]*level[i]) >> PWM_BITS`.
  - Quadratic perceptual correction.
  - The product is computed 2·PWM_BITS wide and the top PWM_BITS are kept.
  - `level_out` still reports the linear level.
- **Undefined:** `duty[i] = level[i]` and no multiplier is instantiated.

## Test plan
All scenarios use `NUM_LED=4`, `PWM_BITS=4`, `RAMP_DIV_BITS=2`, with 8 ns clock period.
- **Reset.** `rst=1` for 2 cycles with `led_in=4'hF` → `led_out=0`, `level_out=0`, `busy=0` throughout the reset and on the first cycle after it.
- **Ramp up.** `led_in=4'b0001`, `max_level=15` → level0 steps 0,1,…,15, one step per 4 cycles, reaching 15 within 64 cycles. `busy` is high during the ramp and drops 1 cycle after level0==15. `led_out[0]` is then high 15 of every 16 cycles; channels 1–3 stay 0.
- **Reversal.** Once level0==6, set `led_in[0]=0` → next steps are 5,4,…,0 with no value skipped or repeated. The FSM ends in OFF and `busy` returns to 0.
- **Cap change.** While ON at 15, set `max_level=4` → level0 falls to 4 and holds, and `led_out[0]` duty becomes 4/16. Raising `max_level` back to 15 makes it rise again.
- **Reset mid-ramp.** Assert `rst` while level0==9 → the next cycle shows all levels 0 and `led_out=0`. After release, the ramp restarts from 0.
- **Gamma.** With `LED_PWM_FADER_GAMMA_EN` defined, hold level0 at 8 via `max_level=8` → `led_out[0]` duty is 4/16 (64>>4), while `level_out` shows 8. Without the macro, the duty is 8/16.
